// File: rtl/save_slot_store.sv
// save_slot_store: three-slot sensor snapshot store answering the save/load
// request interface of the VGA screen controller. A request code must stay
// unchanged for STABLE_CYCLES registered cycles before it acts, once.
// Build option: define SAVE_MERGE_EN to OR each saved snapshot into the slot
// instead of overwriting it.

`timescale 1ns/1ps

module save_slot_tracker #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] code,
  output logic       firing,
  output logic       stay_held,
  output logic [1:0] cand
);
  typedef enum logic [1:0] {IDLE = 2'd0, QUAL = 2'd1, FIRE = 2'd2, HELD = 2'd3} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [1:0] NONE   = 2'd0;

  state_t     state_r, state_s;
  logic [7:0] count_r, count_s;
  logic [1:0] cand_r, cand_s;

  // tracker state, saturating stability counter and candidate code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      count_r <= 8'd0;
      cand_r  <= NONE;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      cand_r  <= cand_s;
    end
  end

  // qualify a stable code, fire once, then hold until the code changes
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    cand_s  = cand_r;
    case (state_r)
      IDLE: begin
        if (code != NONE) begin
          cand_s  = code;
          count_s = 8'd1;
          if (STABLE <= 8'd1) state_s = FIRE;
          else                state_s = QUAL;
        end else begin
          count_s = 8'd0;
        end
      end
      QUAL: begin
        if (code == NONE) begin
          state_s = IDLE;
          count_s = 8'd0;
        end else if (code == cand_r) begin
          if (count_r >= STABLE - 8'd1) begin
            count_s = STABLE;
            state_s = FIRE;
          end else begin
            count_s = count_r + 8'd1;
          end
        end else begin
          cand_s  = code;
          count_s = 8'd1;
          if (STABLE <= 8'd1) state_s = FIRE;
          else                state_s = QUAL;
        end
      end
      FIRE: begin
        state_s = HELD;
      end
      HELD: begin
        if (code == NONE) begin
          state_s = IDLE;
          count_s = 8'd0;
        end else if (code != cand_r) begin
          cand_s  = code;
          count_s = 8'd1;
          if (STABLE <= 8'd1) state_s = FIRE;
          else                state_s = QUAL;
        end else begin
          state_s = HELD;
        end
      end
      default: begin
        state_s = IDLE;
        count_s = 8'd0;
      end
    endcase
  end

  assign firing    = (state_r == FIRE);
  assign stay_held = (state_r == HELD) && (code == cand_r);
  assign cand      = cand_r;
endmodule

module save_slot_store #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DATA_W        = 32
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic [31:0]       save_signal,
  input  logic [31:0]       load_signal,
  input  logic [DATA_W-1:0] sensor_input_to_save,
  output logic [DATA_W-1:0] sensor_output,
  output logic              load_valid,
  output logic [2:0]        slot_valid,
  output logic              save_ack,
  output logic              load_miss
);
  // codes above 3 are treated as NONE
  function automatic logic [1:0] decode_code(input logic [31:0] c);
    if (c[31:2] != 30'd0) return 2'd0;
    else                  return c[1:0];
  endfunction

  logic [1:0]        save_code_r, load_code_r;
  logic [DATA_W-1:0] snap_r;
  logic [DATA_W-1:0] slot_r [3];
  logic [2:0]        slot_valid_r;
  logic [DATA_W-1:0] sensor_output_r;
  logic              load_valid_r, save_ack_r, load_miss_r;

  logic              save_fire_s, save_held_s, load_fire_s, load_held_s;
  logic [1:0]        save_cand_s, load_cand_s;
  logic [DATA_W-1:0] save_old_s, load_old_s, wdata_s, load_data_s;
  logic              load_slot_ok_s, bypass_s, load_hit_s;

  // input capture: all decisions use these registered copies
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      save_code_r <= 2'd0;
      load_code_r <= 2'd0;
      snap_r      <= {DATA_W{1'b0}};
    end else begin
      save_code_r <= decode_code(save_signal);
      load_code_r <= decode_code(load_signal);
      snap_r      <= sensor_input_to_save;
    end
  end

  save_slot_tracker #(.STABLE_CYCLES(STABLE_CYCLES)) u_save_trk (
    .clk(iVGA_CLK), .rst_n(iRST_n), .code(save_code_r),
    .firing(save_fire_s), .stay_held(save_held_s), .cand(save_cand_s)
  );

  save_slot_tracker #(.STABLE_CYCLES(STABLE_CYCLES)) u_load_trk (
    .clk(iVGA_CLK), .rst_n(iRST_n), .code(load_code_r),
    .firing(load_fire_s), .stay_held(load_held_s), .cand(load_cand_s)
  );

  // slot read muxes, write data and same-slot write-through bypass
  always_comb begin
    save_old_s     = {DATA_W{1'b0}};
    load_old_s     = {DATA_W{1'b0}};
    load_slot_ok_s = 1'b0;
    case (save_cand_s)
      2'd1:    save_old_s = slot_r[0];
      2'd2:    save_old_s = slot_r[1];
      2'd3:    save_old_s = slot_r[2];
      default: save_old_s = {DATA_W{1'b0}};
    endcase
    case (load_cand_s)
      2'd1:    begin load_old_s = slot_r[0]; load_slot_ok_s = slot_valid_r[0]; end
      2'd2:    begin load_old_s = slot_r[1]; load_slot_ok_s = slot_valid_r[1]; end
      2'd3:    begin load_old_s = slot_r[2]; load_slot_ok_s = slot_valid_r[2]; end
      default: begin load_old_s = {DATA_W{1'b0}}; load_slot_ok_s = 1'b0; end
    endcase
`ifdef SAVE_MERGE_EN
    wdata_s = save_old_s | snap_r;
`else
    wdata_s = snap_r;
`endif
    bypass_s   = save_fire_s && load_fire_s && (save_cand_s == load_cand_s);
    load_hit_s = bypass_s || load_slot_ok_s;
    if (bypass_s) load_data_s = wdata_s;
    else          load_data_s = load_old_s;
  end

  // slot storage: single write port owned by the save tracker
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < 3; i++) slot_r[i] <= {DATA_W{1'b0}};
      slot_valid_r <= 3'b000;
    end else if (save_fire_s) begin
      for (int i = 0; i < 3; i++) begin
        if (save_cand_s == 2'(i + 1)) begin
          slot_r[i]       <= wdata_s;
          slot_valid_r[i] <= 1'b1;
        end
      end
    end else begin
      slot_valid_r <= slot_valid_r;
    end
  end

  // registered responses: ack/miss pulses, loaded data and its valid flag
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sensor_output_r <= {DATA_W{1'b0}};
      load_valid_r    <= 1'b0;
      save_ack_r      <= 1'b0;
      load_miss_r     <= 1'b0;
    end else begin
      save_ack_r  <= save_fire_s;
      load_miss_r <= load_fire_s && !load_hit_s;
      if (load_fire_s) begin
        sensor_output_r <= load_hit_s ? load_data_s : {DATA_W{1'b0}};
        load_valid_r    <= load_hit_s;
      end else if (load_held_s) begin
        load_valid_r    <= load_valid_r;
      end else begin
        load_valid_r    <= 1'b0;
      end
    end
  end

  assign sensor_output = sensor_output_r;
  assign load_valid    = load_valid_r;
  assign slot_valid    = slot_valid_r;
  assign save_ack      = save_ack_r;
  assign load_miss     = load_miss_r;
endmodule

// File: tb/tb_save_slot_store.sv
// Bench for save_slot_store: a table of request vectors with hand-derived
// expectations queued for the response cycle, plus glitch and reset sequences.

`timescale 1ns/1ps

module tb_save_slot_store;
  localparam int STABLE = 4;
  localparam int LAT    = STABLE + 2;

`ifdef SAVE_MERGE_EN
  localparam logic [31:0] EXP_RELOAD = 32'h0000_00FF;
  localparam logic [31:0] EXP_BYPASS = 32'hA5A5_00FF;
`else
  localparam logic [31:0] EXP_RELOAD = 32'h0000_00F0;
  localparam logic [31:0] EXP_BYPASS = 32'hA5A5_0001;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] save_signal = 32'd0;
  logic [31:0] load_signal = 32'd0;
  logic [31:0] snap = 32'd0;
  logic [31:0] sensor_output;
  logic        load_valid, save_ack, load_miss;
  logic [2:0]  slot_valid;

  save_slot_store #(.STABLE_CYCLES(STABLE), .DATA_W(32)) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n),
    .save_signal(save_signal), .load_signal(load_signal),
    .sensor_input_to_save(snap),
    .sensor_output(sensor_output), .load_valid(load_valid),
    .slot_valid(slot_valid), .save_ack(save_ack), .load_miss(load_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] save_code;
    logic [31:0] load_code;
    logic [31:0] snap;
    int          acks;
    int          misses;
    logic        lv;
    logic [31:0] out;
    logic [2:0]  valid;
    logic [31:0] out_after;
  } vec_t;

  typedef struct {
    int          due;
    logic        ack;
    logic        miss;
    logic        lv;
    logic [31:0] out;
    logic [2:0]  valid;
  } exp_t;

  exp_t q[$];
  vec_t vt[9];
  int   n_vec = 0, n_err = 0, cyc = 0, ack_cnt = 0, miss_cnt = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input logic ack, input logic miss, input logic lv,
                          input logic [31:0] out, input logic [2:0] valid);
    exp_t e;
    e.due = cyc + LAT; e.ack = ack; e.miss = miss; e.lv = lv; e.out = out; e.valid = valid;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    ack_cnt  += int'(save_ack);
    miss_cnt += int'(load_miss);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check32("save_ack",      {31'd0, save_ack},   {31'd0, e.ack});
      check32("load_miss",     {31'd0, load_miss},  {31'd0, e.miss});
      check32("load_valid",    {31'd0, load_valid}, {31'd0, e.lv});
      check32("sensor_output", sensor_output,       e.out);
      check32("slot_valid",    {29'd0, slot_valid}, {29'd0, e.valid});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //        save     load     snapshot      acks miss lv    out           valid   out after release
    vt[0] = '{32'd2, 32'd0, 32'h0000_1234, 1, 0, 1'b0, 32'h0,         3'b010, 32'h0};
    vt[1] = '{32'd0, 32'd2, 32'h0,         0, 0, 1'b1, 32'h0000_1234, 3'b010, 32'h0000_1234};
    vt[2] = '{32'd0, 32'd3, 32'h0,         0, 1, 1'b0, 32'h0,         3'b010, 32'h0};
    vt[3] = '{32'd7, 32'd0, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0,         3'b010, 32'h0};
    vt[4] = '{32'd1, 32'd0, 32'h0000_000F, 1, 0, 1'b0, 32'h0,         3'b011, 32'h0};
    vt[5] = '{32'd1, 32'd0, 32'h0000_00F0, 1, 0, 1'b0, 32'h0,         3'b011, 32'h0};
    vt[6] = '{32'd0, 32'd1, 32'h0,         0, 0, 1'b1, EXP_RELOAD,    3'b011, EXP_RELOAD};
    vt[7] = '{32'd1, 32'd1, 32'hA5A5_0001, 1, 0, 1'b1, EXP_BYPASS,    3'b011, EXP_BYPASS};
    vt[8] = '{32'd3, 32'd2, 32'h0000_0055, 1, 0, 1'b1, 32'h0000_1234, 3'b111, 32'h0000_1234};

    // reset state
    repeat (3) tick();
    check32("rst sensor_output", sensor_output, 32'h0);
    check32("rst slot_valid", {29'd0, slot_valid}, 32'd0);
    check32("rst flags", {29'd0, load_valid, save_ack, load_miss}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // table-driven request vectors
    for (int i = 0; i < 9; i++) begin
      save_signal = vt[i].save_code;
      load_signal = vt[i].load_code;
      snap        = vt[i].snap;
      ack_cnt  = 0;
      miss_cnt = 0;
      push_exp(vt[i].acks != 0, vt[i].misses != 0, vt[i].lv, vt[i].out, vt[i].valid);
      repeat (8) tick();
      save_signal = 32'd0;
      load_signal = 32'd0;
      repeat (3) tick();
      check32($sformatf("v%0d ack count", i), ack_cnt, vt[i].acks);
      check32($sformatf("v%0d miss count", i), miss_cnt, vt[i].misses);
      check32($sformatf("v%0d load_valid released", i), {31'd0, load_valid}, 32'd0);
      check32($sformatf("v%0d sensor_output held", i), sensor_output, vt[i].out_after);
    end

    // glitch before qualification: 1,1,1,0,1... gives exactly one write
    ack_cnt = 0;
    save_signal = 32'd1;
    snap = 32'h0000_0AAA;
    repeat (3) tick();
    save_signal = 32'd0;
    tick();
    save_signal = 32'd1;
    push_exp(1'b1, 1'b0, 1'b0, 32'h0000_1234, 3'b111);
    repeat (LAT - 1) tick();
    check32("glitch no early ack", ack_cnt, 0);
    repeat (7) tick();
    check32("glitch single ack", ack_cnt, 1);
    save_signal = 32'd0;
    repeat (3) tick();

    // reset during qualification, then during FIRE: no write survives
    ack_cnt = 0;
    save_signal = 32'd3;
    snap = 32'h0000_0077;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check32("rst mid-qual slot_valid", {29'd0, slot_valid}, 32'd0);
    check32("rst mid-qual sensor_output", sensor_output, 32'h0);
    save_signal = 32'd0;
    rst_n = 1'b1;
    repeat (3) tick();
    save_signal = 32'd2;
    snap = 32'h0000_0099;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    save_signal = 32'd0;
    rst_n = 1'b1;
    repeat (3) tick();
    check32("rst mid-fire slot_valid", {29'd0, slot_valid}, 32'd0);
    check32("rst no ack", ack_cnt, 0);
    miss_cnt = 0;
    load_signal = 32'd2;
    push_exp(1'b0, 1'b1, 1'b0, 32'h0, 3'b000);
    repeat (8) tick();
    load_signal = 32'd0;
    repeat (3) tick();
    check32("post-reset load miss count", miss_cnt, 1);

    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: %0d expected responses never checked", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
